ltpi_nl_gpio_scheduler: RTL and testbench



---
 rtl/ltpi_nl_gpio_scheduler.sv | 136 +++++++++++++
 tb/tb_ltpi_nl_gpio_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ltpi_nl_gpio_scheduler.sv
// Shares the single NL GPIO slot of each LTPI frame among all NL GPIO slices:
// an initial full sweep after alignment, then dirty slices first with periodic round-robin refresh.
module ltpi_nl_gpio_scheduler #(
  parameter int NL_GPIO_WIDTH    = 1024,
  parameter int SLICE_WIDTH      = 16,
  parameter int REFRESH_INTERVAL = 8,
  localparam int NUM_SLICES      = NL_GPIO_WIDTH / SLICE_WIDTH,
  localparam int IDX_W           = $clog2(NUM_SLICES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     aligned,
  input  logic [NL_GPIO_WIDTH-1:0] nl_gpio_in,
  input  logic                     slot_req,
  output logic                     slot_valid,
  output logic [IDX_W-1:0]         slot_index,
  output logic [SLICE_WIDTH-1:0]   slot_data,
  output logic                     nl_gpio_stable
);

  localparam int                CNT_W        = $clog2(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0]  REFRESH_LAST = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [IDX_W-1:0]  LAST_SLICE   = IDX_W'(NUM_SLICES - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE      = IDX_W'(1);
  localparam logic [IDX_W:0]    NUM_SLICES_W = (IDX_W + 1)'(NUM_SLICES);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_RUN} state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       sweep_ptr_reg;
  logic [IDX_W-1:0]       rr_ptr_reg;
  logic [IDX_W-1:0]       dirty_ptr_reg;
  logic [CNT_W-1:0]       refresh_cnt_reg;
  logic [SLICE_WIDTH-1:0] sent_reg [NUM_SLICES];

  logic [SLICE_WIDTH-1:0] in_slice [NUM_SLICES];
  logic [NUM_SLICES-1:0]  dirty;
  logic [NUM_SLICES-1:0]  dirty_rot;
  logic [IDX_W-1:0]       dirty_off;
  logic [IDX_W-1:0]       dirty_pick;
  logic                   any_dirty;
  logic                   use_dirty;
  logic [IDX_W-1:0]       grant_idx;
  logic [SLICE_WIDTH-1:0] grant_data;

  // Modular add over the slice index space (NUM_SLICES need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NUM_SLICES_W) s = s - NUM_SLICES_W;
    return s[IDX_W-1:0];
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      assign in_slice[gi] = nl_gpio_in[gi*SLICE_WIDTH +: SLICE_WIDTH];
      assign dirty[gi]    = (in_slice[gi] != sent_reg[gi]);
    end
  endgenerate

  // Rotate so bit 0 is dirty_ptr, then take the lowest set bit: first dirty at or after the pointer.
  assign dirty_rot = NUM_SLICES'({dirty, dirty} >> dirty_ptr_reg);

  always_comb begin
    dirty_off = '0;
    for (int i = NUM_SLICES - 1; i >= 0; i--) begin
      if (dirty_rot[i]) dirty_off = IDX_W'(i);
    end
  end

  assign any_dirty  = |dirty;
  assign dirty_pick = wrap_add(dirty_ptr_reg, dirty_off);
  assign use_dirty  = any_dirty && (refresh_cnt_reg != REFRESH_LAST);
  assign grant_idx  = (state_reg == ST_SWEEP) ? sweep_ptr_reg :
                      (use_dirty ? dirty_pick : rr_ptr_reg);
  assign grant_data = in_slice[grant_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      sweep_ptr_reg   <= '0;
      rr_ptr_reg      <= '0;
      dirty_ptr_reg   <= '0;
      refresh_cnt_reg <= '0;
      slot_valid      <= 1'b0;
      slot_index      <= '0;
      slot_data       <= '0;
      nl_gpio_stable  <= 1'b0;
      for (int i = 0; i < NUM_SLICES; i++) sent_reg[i] <= '0;
    end else if (!aligned) begin
      // Link loss: drop back and forget progress; the shadow is kept since the next sweep resends all.
      state_reg       <= ST_IDLE;
      sweep_ptr_reg   <= '0;
      rr_ptr_reg      <= '0;
      dirty_ptr_reg   <= '0;
      refresh_cnt_reg <= '0;
      slot_valid      <= 1'b0;
      nl_gpio_stable  <= 1'b0;
    end else begin
      slot_valid <= 1'b0;
      if (slot_req && (state_reg == ST_SWEEP || state_reg == ST_RUN)) begin
        slot_valid          <= 1'b1;
        slot_index          <= grant_idx;
        slot_data           <= grant_data;
        sent_reg[grant_idx] <= grant_data;
      end
      case (state_reg)
        ST_IDLE: state_reg <= ST_SWEEP;
        ST_SWEEP: begin
          if (slot_req) begin
            sweep_ptr_reg <= wrap_add(sweep_ptr_reg, IDX_ONE);
            if (sweep_ptr_reg == LAST_SLICE) begin
              state_reg      <= ST_RUN;
              nl_gpio_stable <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (slot_req) begin
            if (use_dirty) begin
              dirty_ptr_reg   <= wrap_add(dirty_pick, IDX_ONE);
              refresh_cnt_reg <= refresh_cnt_reg + CNT_W'(1);
            end else begin
              // Refresh slot, either forced by the counter or because nothing is dirty.
              rr_ptr_reg      <= wrap_add(rr_ptr_reg, IDX_ONE);
              refresh_cnt_reg <= '0;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltpi_nl_gpio_scheduler.sv
// Bench for ltpi_nl_gpio_scheduler: vector table, directed corner sequences and a random run
// checked every cycle against a rule-level reference model.
module tb_ltpi_nl_gpio_scheduler;
  localparam int W       = 1024;
  localparam int SW      = 16;
  localparam int R       = 8;
  localparam int NS      = W / SW;
  localparam int IW      = $clog2(NS);
  // One dirty-pointer lap plus the refresh slots that interleave with it.
  localparam int GAP_MAX = NS + NS / (R - 1) + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          aligned;
  logic [W-1:0]  nl_gpio_in;
  logic          slot_req;
  logic          slot_valid;
  logic [IW-1:0] slot_index;
  logic [SW-1:0] slot_data;
  logic          nl_gpio_stable;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ltpi_nl_gpio_scheduler #(.NL_GPIO_WIDTH(W), .SLICE_WIDTH(SW), .REFRESH_INTERVAL(R)) dut (
    .clk(clk), .rst_n(rst_n), .aligned(aligned), .nl_gpio_in(nl_gpio_in),
    .slot_req(slot_req), .slot_valid(slot_valid), .slot_index(slot_index),
    .slot_data(slot_data), .nl_gpio_stable(nl_gpio_stable)
  );

  typedef struct {
    bit r; bit a; bit q;
    bit v; int idx; bit st;
  } vec_t;
  vec_t tbl[11];

  // Reference model state: mode 0=idle, 1=sweep, 2=run.
  int            m_mode, m_sweep, m_rr, m_dptr, m_rcnt;
  logic [SW-1:0] m_sent [NS];
  bit            e_valid, e_stable;
  int            e_idx;
  logic [SW-1:0] e_data;

  function automatic logic [SW-1:0] slice_of(input logic [W-1:0] v, input int i);
    return v[i*SW +: SW];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  g;
    bit  grant;
    int  found;
    g = 0; grant = 0; e_valid = 0;
    if (!rst_n) begin
      m_mode = 0; m_sweep = 0; m_rr = 0; m_dptr = 0; m_rcnt = 0;
      e_stable = 0; e_idx = 0; e_data = '0;
      for (int i = 0; i < NS; i++) m_sent[i] = '0;
    end else if (!aligned) begin
      m_mode = 0; m_sweep = 0; m_rr = 0; m_dptr = 0; m_rcnt = 0;
      e_stable = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (slot_req) begin
      grant = 1;
      if (m_mode == 1) begin
        g = m_sweep;
        m_sweep = (m_sweep + 1) % NS;
        if (g == NS - 1) begin m_mode = 2; e_stable = 1; end
      end else if (m_rcnt == R - 1) begin
        g = m_rr; m_rr = (m_rr + 1) % NS; m_rcnt = 0;
      end else begin
        found = -1;
        for (int k = 0; k < NS && found < 0; k++)
          if (slice_of(nl_gpio_in, (m_dptr + k) % NS) != m_sent[(m_dptr + k) % NS])
            found = (m_dptr + k) % NS;
        if (found >= 0) begin
          g = found; m_dptr = (found + 1) % NS; m_rcnt++;
        end else begin
          g = m_rr; m_rr = (m_rr + 1) % NS; m_rcnt = 0;
        end
      end
    end
    if (grant) begin
      e_valid = 1; e_idx = g; e_data = slice_of(nl_gpio_in, g); m_sent[g] = e_data;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic cycle(input bit r, input bit a, input bit q);
    rst_n = r; aligned = a; slot_req = q;
    @(posedge clk);
    model_step();
    #1;
    check("valid", slot_valid, e_valid);
    check("stable", nl_gpio_stable, e_stable);
    if (e_valid) begin
      check("index", slot_index, e_idx);
      check("data", slot_data, e_data);
    end
    if (slot_valid)
      $display("grant idx=%0d data=%04h stable=%0d", slot_index, slot_data, nl_gpio_stable);
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NS; i++) nl_gpio_in[i*SW +: SW] = 16'($urandom);
  endtask

  initial begin
    int  g, exp_i, gap, cyc, b;
    bit  r, q, al_r;
    int  last_sent [NS];

    tbl[0]  = '{0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 0, 0};
    tbl[3]  = '{1, 1, 1, 1, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 1, 1, 0};
    tbl[6]  = '{1, 1, 1, 1, 2, 0};
    tbl[7]  = '{1, 0, 1, 0, 0, 0};
    tbl[8]  = '{1, 1, 1, 0, 0, 0};
    tbl[9]  = '{1, 1, 1, 1, 0, 0};
    tbl[10] = '{1, 1, 1, 1, 1, 0};

    randomize_inputs();
    cycle(0, 0, 1);
    check("rst_valid", slot_valid, 0);
    check("rst_index", slot_index, 0);
    check("rst_data", slot_data, 0);
    check("rst_stable", nl_gpio_stable, 0);

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].r, tbl[i].a, tbl[i].q);
      check("tbl_valid", slot_valid, tbl[i].v);
      check("tbl_stable", nl_gpio_stable, tbl[i].st);
      if (tbl[i].v) begin
        check("tbl_index", slot_index, tbl[i].idx);
        check("tbl_data", slot_data, slice_of(nl_gpio_in, tbl[i].idx));
      end
    end

    // Full sweep from reset, back-to-back requests.
    randomize_inputs();
    nl_gpio_in[4] = 1'b0;
    cycle(0, 0, 0);
    cycle(1, 1, 0);
    for (int k = 0; k < NS; k++) begin
      cycle(1, 1, 1);
      check("sweep_valid", slot_valid, 1);
      check("sweep_idx", slot_index, k);
      check("sweep_data", slot_data, slice_of(nl_gpio_in, k));
      check("sweep_stable", nl_gpio_stable, k == NS - 1);
    end

    // Static inputs: pure round robin.
    for (int k = 0; k < 16; k++) begin
      cycle(1, 1, 1);
      check("rr_idx", slot_index, k);
    end
    nl_gpio_in[4] = 1'b1;
    cycle(1, 1, 1);
    check("toggle_idx", slot_index, 0);
    check("toggle_bit4", slot_data[4], 1);

    // Park dirty_ptr at 11, then dirty 3, 10 and 60 together.
    nl_gpio_in[10*SW +: SW] = ~nl_gpio_in[10*SW +: SW];
    cycle(1, 1, 1);
    check("park_idx", slot_index, 10);
    nl_gpio_in[3*SW +: SW]  = ~nl_gpio_in[3*SW +: SW];
    nl_gpio_in[10*SW +: SW] = ~nl_gpio_in[10*SW +: SW];
    nl_gpio_in[60*SW +: SW] = ~nl_gpio_in[60*SW +: SW];
    cycle(1, 1, 1); check("multi_0", slot_index, 60);
    cycle(1, 1, 1); check("multi_1", slot_index, 3);
    cycle(1, 1, 1); check("multi_2", slot_index, 10);
    cycle(1, 1, 1); check("multi_rr", slot_index, 16);

    // Every slice changes every cycle: 7 dirty grants then one refresh, repeatedly.
    cyc = 0;
    for (int i = 0; i < NS; i++) last_sent[i] = 0;
    cycle(0, 0, 0);
    for (int n = 0; n < 1 + NS + 200; n++) begin
      cyc++;
      for (int i = 0; i < NS; i++) nl_gpio_in[i*SW +: SW] = 16'(cyc) ^ 16'(i);
      cycle(1, 1, n > 0);
      if (n > NS) begin
        g = n - NS;
        if (g % R == 0) exp_i = (g / R - 1) % NS;
        else            exp_i = (g - g / R - 1) % NS;
        check("churn_idx", slot_index, exp_i);
        gap = g - last_sent[slot_index];
        check("churn_gap_ok", gap <= GAP_MAX, 1);
        last_sent[slot_index] = g;
      end
    end
    for (int i = 0; i < NS; i++) check("churn_starve_ok", (200 - last_sent[i]) <= GAP_MAX, 1);

    // Link loss mid-sweep with a request in flight.
    randomize_inputs();
    cycle(0, 0, 0);
    cycle(1, 1, 0);
    for (int k = 0; k < 20; k++) cycle(1, 1, 1);
    check("pre_drop_idx", slot_index, 19);
    cycle(1, 0, 1);
    check("drop_valid", slot_valid, 0);
    check("drop_stable", nl_gpio_stable, 0);
    cycle(1, 1, 1);
    check("realign_valid", slot_valid, 0);
    cycle(1, 1, 1);
    check("restart_valid", slot_valid, 1);
    check("restart_idx", slot_index, 0);
    for (int k = 1; k < NS; k++) cycle(1, 1, 1);
    check("resweep_stable", nl_gpio_stable, 1);

    // Reset in RUN with a request pending.
    nl_gpio_in[7*SW +: SW] = ~nl_gpio_in[7*SW +: SW];
    cycle(1, 1, 1);
    cycle(1, 1, 1);
    cycle(0, 1, 1);
    check("runrst_valid", slot_valid, 0);
    check("runrst_index", slot_index, 0);
    check("runrst_data", slot_data, 0);
    check("runrst_stable", nl_gpio_stable, 0);
    cycle(1, 1, 1);
    check("runrst_idle", slot_valid, 0);
    cycle(1, 1, 1);
    check("runrst_sweep_idx", slot_index, 0);

    // Random traffic against the model.
    al_r = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(399) != 0);
      if ($urandom_range(499) == 0) al_r = ~al_r;
      q = ($urandom_range(2) != 0);
      if ($urandom_range(3) == 0) begin
        b = $urandom_range(W - 1);
        nl_gpio_in[b] = ~nl_gpio_in[b];
      end
      if ($urandom_range(63) == 0)
        for (int i = 0; i < NS; i += 5) nl_gpio_in[i*SW +: SW] = 16'($urandom);
      cycle(r, al_r, q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
